// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and GF(2^8) helpers used by the key expander
// and its round transform.
package aes_pkg;

  localparam int AES_KEY_W      = 128;
  localparam int AES_NUM_ROUNDS = 10;

  typedef logic [AES_KEY_W-1:0] aes_key_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KICK  = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } kexp_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < 15; i++) begin
      r = (4'(i) < round) ? gf_mul(r, 8'h02) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/round_key_tf.sv
// One AES-128 key-schedule step: derives round key N from round key N-1.
// done_o pulses one cycle after start_i, with key_o valid from then on.
module round_key_tf
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [AES_KEY_W-1:0] key_i,
  input  logic [3:0]           round_count_i,
  output logic [AES_KEY_W-1:0] key_o,
  output logic                 done_o
);

  logic [31:0]          temp_s;
  logic [AES_KEY_W-1:0] next_s;
  logic [AES_KEY_W-1:0] key_q;
  logic                 done_q;

  always_comb begin
    temp_s = {sbox(key_i[23:16]), sbox(key_i[15:8]), sbox(key_i[7:0]), sbox(key_i[31:24])}
             ^ {rcon(round_count_i), 24'h000000};
    next_s[127:96] = key_i[127:96] ^ temp_s;
    next_s[95:64]  = key_i[95:64]  ^ next_s[127:96];
    next_s[63:32]  = key_i[63:32]  ^ next_s[95:64];
    next_s[31:0]   = key_i[31:0]   ^ next_s[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      done_q <= 1'b0;
    end else if (start_i) begin
      key_q  <= next_s;
      done_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign key_o  = key_q;
  assign done_o = done_q;

endmodule

// File: rtl/aes_key_expander.sv
// Expands an AES-128 master key into NUM_ROUNDS+1 round keys held in a flop store,
// served combinationally by index; early slots become readable while expansion runs.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_W      = AES_KEY_W,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             keys_valid_o,
  input  logic [3:0]       rd_idx_i,
  output logic [KEY_W-1:0] rd_key_o,
  output logic             rd_valid_o
);

  if (NUM_ROUNDS > 15) begin : g_rounds_check
    $error("aes_key_expander: NUM_ROUNDS must fit the 4-bit round counter");
  end

  kexp_state_e      state_q, state_d;
  logic [3:0]       round_q;
  logic [3:0]       written_q;
  logic             any_q;
  logic             busy_q, done_q, kv_q;
  logic [KEY_W-1:0] slot_q [0:NUM_ROUNDS];
  logic             tf_start_s, tf_done_s;
  logic [KEY_W-1:0] tf_key_s, tf_key_o;

  round_key_tf u_tf (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (tf_start_s),
    .key_i         (tf_key_s),
    .round_count_i (round_q),
    .key_o         (tf_key_o),
    .done_o        (tf_done_s)
  );

  always_comb begin
    state_d    = state_q;
    tf_start_s = 1'b0;
    case (state_q)
      IDLE:    state_d = start_i ? KICK : IDLE;
      KICK: begin
        tf_start_s = 1'b1;
        state_d    = WAIT;
      end
      WAIT:    state_d = tf_done_s ? STORE : WAIT;
      STORE:   state_d = (round_q == 4'(NUM_ROUNDS)) ? DONE : KICK;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux and transform operand select (slot[round-1]) share one sweep of the store.
  always_comb begin
    rd_key_o = '0;
    tf_key_s = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      rd_key_o = (rd_idx_i == 4'(i))     ? slot_q[i] : rd_key_o;
      tf_key_s = (round_q  == 4'(i + 1)) ? slot_q[i] : tf_key_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      round_q   <= 4'd1;
      written_q <= 4'd0;
      any_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      kv_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == DONE);
      if (state_q == IDLE && start_i) begin
        round_q   <= 4'd1;
        written_q <= 4'd0;
        any_q     <= 1'b1;
        kv_q      <= 1'b0;
      end else if (state_q == STORE) begin
        written_q <= round_q;
        if (round_q != 4'(NUM_ROUNDS)) begin
          round_q <= round_q + 4'd1;
        end
      end else if (state_q == DONE) begin
        kv_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && start_i) begin
        slot_q[0] <= key_i;
      end
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        if (state_q == STORE && round_q == 4'(i)) begin
          slot_q[i] <= tf_key_o;
        end
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign keys_valid_o = kv_q;
  assign rd_valid_o   = any_q && (rd_idx_i <= written_q);

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench: a word-level FIPS-197 key schedule plus a cycle-count timeline
// model predict every output each cycle; literal vectors pin the model itself.
module tb_aes_key_expander;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam int           LAT = 32;

  typedef logic [127:0] sched_t [0:10];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [3:0]   rd_idx_i = 4'd0;
  logic         busy_o, done_o, keys_valid_o, rd_valid_o;
  logic [127:0] rd_key_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb [0:255];

  // model state
  logic         m_busy, m_done, m_kv, m_any;
  logic [3:0]   m_written;
  int           m_t;
  logic [127:0] m_slots [0:10];
  sched_t       m_sched;

  aes_key_expander dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .keys_valid_o (keys_valid_o),
    .rd_idx_i     (rd_idx_i),
    .rd_key_o     (rd_key_o),
    .rd_valid_o   (rd_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic sched_t expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // Timeline model: slot r appears 3r+1 cycles after acceptance, done at cycle 32.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_kv <= 1'b0; m_any <= 1'b0;
      m_written <= 4'd0; m_t <= 0;
      for (int i = 0; i < 11; i++) m_slots[i] <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && start_i) begin
        m_sched    <= expand(key_i);
        m_slots[0] <= key_i;
        m_written  <= 4'd0;
        m_any      <= 1'b1;
        m_kv       <= 1'b0;
        m_t        <= 1;
        m_busy     <= 1'b1;
      end else if (m_busy) begin
        m_t <= m_t + 1;
        if ((m_t + 1) % 3 == 1) begin
          m_slots[m_t / 3] <= m_sched[m_t / 3];
          m_written        <= 4'(m_t / 3);
        end
        if (m_t + 1 == LAT) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_kv <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int idx;
    idx = int'(rd_idx_i);
    check("busy_o", 128'(busy_o), 128'(m_busy));
    check("done_o", 128'(done_o), 128'(m_done));
    check("keys_valid_o", 128'(keys_valid_o), 128'(m_kv));
    check("rd_valid_o", 128'(rd_valid_o), 128'(m_any && idx <= int'(m_written) && idx <= 10));
    check("rd_key_o", rd_key_o, (idx <= 10) ? m_slots[idx] : 128'h0);
  end

  task automatic do_start(input logic [127:0] k);
    @(posedge clk); #1;
    start_i = 1'b1;
    key_i   = k;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_exp(input bit rnd, input int inj_t, input logic [127:0] inj_key,
                         output int ndone, output int rise);
    ndone = 0;
    rise  = -1;
    for (int c = 0; c < 60 && ndone == 0; c++) begin
      @(posedge clk); #1;
      if (rnd) rd_idx_i = 4'($urandom_range(0, 15));
      start_i = m_busy && (m_t == inj_t);
      key_i   = inj_key;
      @(negedge clk);
      if (rd_valid_o && rise < 0) rise = m_t;
      if (done_o) ndone++;
    end
    start_i = 1'b0;
    check("expansion_completes", 128'(ndone), 128'd1);
  endtask

  task automatic read_lit(input string name, input logic [3:0] idx, input logic [127:0] exp);
    rd_idx_i = idx;
    #1;
    check(name, rd_key_o, exp);
  endtask

  initial begin
    int ndone, rise, extra;
    sched_t s;
    logic [7:0] inv, b;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
      sb[x] = b;
    end
    s = expand(K1);
    check("model_k1_slot1", s[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_k1_slot10", s[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    s = expand(K3);
    check("model_k3_slot10", s[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 128'(busy_o), 128'd0);
    check("reset_kv", 128'(keys_valid_o), 128'd0);
    check("reset_rd_valid", 128'(rd_valid_o), 128'd0);
    check("reset_rd_key", rd_key_o, 128'd0);

    // reference expansion while polling slot 3
    rd_idx_i = 4'd3;
    do_start(K1);
    run_exp(1'b0, 0, '0, ndone, rise);
    check("slot3_valid_rise_cycle", 128'(rise), 128'd10);
    check("kv_after_done", 128'(keys_valid_o), 128'd1);
    read_lit("k1_slot1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_lit("k1_slot3", 4'd3, 128'h3d80477d4716fe3e1e237e446d7a883b);
    read_lit("k1_slot10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // start pulse during round 5 is ignored
    do_start(K1);
    run_exp(1'b1, 15, ~K1, ndone, rise);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    check("single_done_pulse", 128'(ndone + extra), 128'd1);
    read_lit("k1_slot10_after_ignored_start", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // reset in WAIT of round 7
    do_start(K1);
    ndone = 0;
    for (int c = 0; c < 60 && m_t != 20; c++) begin
      @(posedge clk); #1;
      if (done_o) ndone++;
    end
    check("reached_round7_wait", 128'(m_t), 128'd20);
    rd_idx_i = 4'd3;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 128'(busy_o), 128'd0);
    check("midreset_done", 128'(done_o | (ndone != 0)), 128'd0);
    check("midreset_kv", 128'(keys_valid_o), 128'd0);
    check("midreset_rd_valid", 128'(rd_valid_o), 128'd0);
    check("midreset_rd_key", rd_key_o, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_start(K1);
    run_exp(1'b1, 0, '0, ndone, rise);
    read_lit("k1_slot10_after_reset", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // back-to-back start in the cycle after done_o
    do_start(K1);
    run_exp(1'b1, 0, '0, ndone, rise);
    check("kv_at_done", 128'(keys_valid_o), 128'd1);
    do_start(K3);
    check("kv_drops_after_restart", 128'(keys_valid_o), 128'd0);
    run_exp(1'b1, 0, '0, ndone, rise);
    read_lit("k3_slot1", 4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    read_lit("k3_slot10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // out-of-range indices while idle
    for (int i = 11; i < 16; i++) begin
      rd_idx_i = 4'(i);
      #1;
      check("oor_rd_key", rd_key_o, 128'd0);
      check("oor_rd_valid", 128'(rd_valid_o), 128'd0);
    end

    // random keys, random read indices
    repeat (4) begin
      do_start({$urandom, $urandom, $urandom, $urandom});
      run_exp(1'b1, int'($urandom_range(2, 30)), {$urandom, $urandom, $urandom, $urandom}, ndone, rise);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
